// File: rtl/reg_file.sv
// Eight-entry register file with two combinational read ports and one
// synchronous write port; R0 is hardwired to zero and has no storage.
module reg_file #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ra,
  input  logic [2:0]       rb,
  input  logic [WIDTH-1:0] d,
  input  logic [2:0]       writeAddr,
  input  logic             writeEnable,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);

  localparam int unsigned AW    = 3;
  localparam int unsigned NREGS = 8;

  // Storage for R1..R7 only; address 0 never matches an entry.
  logic [WIDTH-1:0] regs [1:NREGS-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (writeEnable && (writeAddr == AW'(i))) begin
          regs[i] <= d;
        end
      end
    end
  end

  // Read muxes; an address of 0 falls through to the zero default.
  always_comb begin
    a = '0;
    b = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (ra == AW'(i)) a = regs[i];
      if (rb == AW'(i)) b = regs[i];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected read values from
// an array model, a monitor process compares them against the DUT outputs.
module tb_reg_file;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   ra_w, rb_w, wa_w;
  logic [W-1:0] d;
  logic         we;
  logic [W-1:0] a, b;

  logic [W-1:0] model [8];

  typedef struct {
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    string        name;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   total = 0;
  int   bad   = 0;

  reg_file #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ra         (ra_w[2:0]),
    .rb         (rb_w[2:0]),
    .d          (d),
    .writeAddr  (wa_w[2:0]),
    .writeEnable(we),
    .a          (a),
    .b          (b)
  );

  always #5 clk = ~clk;

  // Monitor: compare the current DUT outputs against each queued expectation.
  initial begin
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        total++;
        if (a !== e.ea) begin
          bad++;
          $display("FAIL %s port a: got %h expected %h", e.name, a, e.ea);
        end
        total++;
        if (b !== e.eb) begin
          bad++;
          $display("FAIL %s port b: got %h expected %h", e.name, b, e.eb);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb);
    exp_t e;
    e.ea = ea;
    e.eb = eb;
    e.name = name;
    q.push_back(e);
    ->chk_ev;
    #1;
  endtask

  // Reference read: addresses wrap modulo 8, and entry 0 is never written.
  function automatic logic [W-1:0] rd(input logic [3:0] addr);
    return model[int'(addr) % 8];
  endfunction

  task automatic check_model(input string name);
    check(name, rd(ra_w), rd(rb_w));
  endtask

  // Apply the architectural write rule to the model at a rising edge.
  task automatic model_edge();
    if (reset && we && (int'(wa_w) % 8) != 0) model[int'(wa_w) % 8] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [W-1:0] val);
    @(negedge clk);
    we = 1'b1; wa_w = addr; d = val; ra_w = addr; rb_w = addr;
    #1 check_model("write_pre");
    @(posedge clk);
    #1 model_edge();
    check_model("write_post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    clear_model();
    reset = 1'b0; we = 1'b1; wa_w = 4'd1; d = 16'h0005; ra_w = 4'd1; rb_w = 4'd1;
    #2 check("reset_init", 16'h0000, 16'h0000);

    // Writes are blocked while reset is low.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check("reset_blocks_write", 16'h0000, 16'h0000);
    end

    // Release reset; rb driven as 8 truncates to R0.
    @(negedge clk);
    reset = 1'b1; rb_w = 4'd8;
    #1 check("pre_first_write", 16'h0000, 16'h0000);
    @(posedge clk);
    #1 model_edge();
    check("basic_write", 16'h0005, 16'h0000);

    // R0 write-protect, address driven as 8.
    @(negedge clk);
    wa_w = 4'd8; d = 16'h0001; ra_w = 4'd1; rb_w = 4'd0;
    @(posedge clk);
    #1 model_edge();
    check("r0_protect", 16'h0005, 16'h0000);

    // Write enable low.
    @(negedge clk);
    we = 1'b0; wa_w = 4'd3; d = 16'hBEEF; ra_w = 4'd3;
    @(posedge clk);
    #1 model_edge();
    check("we_low", 16'h0000, 16'h0000);

    // Load every register and sweep both ports.
    for (int k = 1; k < 8; k++) write_reg(4'(k), W'(32'h1111 * k));
    @(negedge clk);
    we = 1'b0;
    for (int k = 1; k < 8; k++) begin
      ra_w = 4'(k); rb_w = 4'(7 - k);
      #1 check("dual_port_sweep", W'(32'h1111 * k), W'(32'h1111 * (7 - k)));
    end

    // Asynchronous reset between edges, then stays cleared after release.
    @(negedge clk);
    ra_w = 4'd3; rb_w = 4'd5;
    #1 check("before_async_reset", 16'h3333, 16'h5555);
    #1 reset = 1'b0;
    #1 check("async_reset_immediate", 16'h0000, 16'h0000);
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("after_reset_release", 16'h0000, 16'h0000);

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      ra_w = 4'($urandom_range(0, 15));
      rb_w = 4'($urandom_range(0, 15));
      wa_w = 4'($urandom_range(0, 15));
      d    = W'($urandom);
      we   = ($urandom_range(0, 3) != 0);
      #1 check_model("rand_pre_edge");
      if ($urandom_range(0, 24) == 0) begin
        #1 reset = 1'b0;
        clear_model();
        #1 check_model("rand_async_reset");
        #1 reset = 1'b1;
      end
      @(posedge clk);
      #1 model_edge();
      check_model("rand_post_edge");
    end

    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
